// File: rtl/cpu6502_pkg.sv
// Shared codes for the 6502 interrupt entry sequencer: vector kinds, push selects, states, ADL masks.
// Pure declarations, no logic or latency.
// No flow control involved.
package cpu6502_pkg;

  typedef enum logic [1:0] {
    VEC_IRQ = 2'd0,
    VEC_NMI = 2'd1,
    VEC_RES = 2'd2
  } vec_kind_e;

  typedef enum logic [1:0] {
    PUSH_NONE = 2'd0,
    PUSH_PCH  = 2'd1,
    PUSH_PCL  = 2'd2,
    PUSH_P    = 2'd3
  } push_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_T7   = 3'd7
  } seq_state_e;

  // ADL pulldown masks as {adl2, adl1, adl0}; ADL precharges to FF.
  localparam logic [2:0] ADL_LO_IRQ = 3'b001;  // FE
  localparam logic [2:0] ADL_HI_IRQ = 3'b000;  // FF
  localparam logic [2:0] ADL_LO_NMI = 3'b101;  // FA
  localparam logic [2:0] ADL_HI_NMI = 3'b100;  // FB
  localparam logic [2:0] ADL_LO_RES = 3'b011;  // FC
  localparam logic [2:0] ADL_HI_RES = 3'b010;  // FD

  function automatic logic [2:0] adl_mask(input vec_kind_e kind, input logic hi);
    case (kind)
      VEC_NMI: adl_mask = hi ? ADL_HI_NMI : ADL_LO_NMI;
      VEC_RES: adl_mask = hi ? ADL_HI_RES : ADL_LO_RES;
      default: adl_mask = hi ? ADL_HI_IRQ : ADL_LO_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Latches a rising edge of the NMI line until the sequencer consumes it.
// Pending flag rises one cycle after the line goes high.
// No backpressure; a new edge in the clear cycle wins over the clear.
module nmi_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_nmi,
  input  logic i_clr,
  output logic o_pend
);

  logic nmi_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      nmi_q  <= 1'b0;
      o_pend <= 1'b0;
    end else begin
      nmi_q  <= i_nmi;
      o_pend <= (o_pend & ~i_clr) | (i_nmi & ~nmi_q);
    end
  end

endmodule

// File: rtl/interrupt_vector_sequencer.sv
// Seven-cycle RES/NMI/IRQ/BRK entry: pushes PCH, PCL, P to page 01, then fetches the vector.
// Start decided at i_sync, T1 on the next edge; strobes are decoded from registered state.
// No backpressure; RES restarts the sequence from T1 at any point.
module interrupt_vector_sequencer
  import cpu6502_pkg::*;
#(
  parameter bit RES_SUPPRESS_WR = 1'b1,
  parameter bit NMI_HIJACK      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sync,
  input  logic       i_res_req,
  input  logic       i_nmi,
  input  logic       i_irq,
  input  logic       i_i_flag,
  input  logic       i_brk,
  output logic       o_busy,
  output logic       o_rw,
  output logic       o_pc_inc,
  output logic [1:0] o_push_sel,
  output logic       o_b_flag,
  output logic       o_sp_dec,
  output logic       o_0_adl0,
  output logic       o_0_adl1,
  output logic       o_0_adl2,
  output logic       o_0_adh0,
  output logic       o_0_adh1_7,
  output logic       o_pcl_load,
  output logic       o_pch_load,
  output logic       o_set_i,
  output logic [1:0] o_vec_kind,
  output logic       o_done
);

  seq_state_e state_q, state_d;
  vec_kind_e  kind_q, kind_d;
  logic       brk_q, brk_d;
  logic       nmi_pend;
  logic       nmi_clr;
  logic       push_en;

  assign nmi_clr = (state_q == ST_T6) && (kind_q == VEC_NMI);

  nmi_edge_detect u_nmi_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_nmi   (i_nmi),
    .i_clr   (nmi_clr),
    .o_pend  (nmi_pend)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    brk_d   = brk_q;
    case (state_q)
      ST_IDLE: begin
        if (i_sync) begin
          if (i_res_req) begin
            state_d = ST_T1;
            kind_d  = VEC_RES;
            brk_d   = 1'b0;
          end else if (nmi_pend) begin
            state_d = ST_T1;
            kind_d  = VEC_NMI;
            brk_d   = 1'b0;
          end else if (i_irq && !i_i_flag) begin
            state_d = ST_T1;
            kind_d  = VEC_IRQ;
            brk_d   = 1'b0;
          end else if (i_brk) begin
            state_d = ST_T1;
            kind_d  = VEC_IRQ;
            brk_d   = 1'b1;
          end
        end
      end
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = ST_T4;
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = ST_T6;
      ST_T6:   state_d = ST_T7;
      default: state_d = ST_IDLE;
    endcase

    // Hijack keeps brk_q, so the pushed B bit still reflects a BRK.
    if (NMI_HIJACK && (kind_q == VEC_IRQ) && nmi_pend &&
        (state_q inside {ST_T1, ST_T2, ST_T3, ST_T4, ST_T5}))
      kind_d = VEC_NMI;

    if ((state_q != ST_IDLE) && i_res_req) begin
      state_d = ST_T1;
      kind_d  = VEC_RES;
      brk_d   = 1'b0;
    end

    if (state_d == ST_IDLE) begin
      kind_d = VEC_IRQ;
      brk_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      kind_q  <= VEC_IRQ;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      brk_q   <= brk_d;
    end
  end

  assign push_en = !(RES_SUPPRESS_WR && (kind_q == VEC_RES));

  always_comb begin
    o_busy     = (state_q != ST_IDLE);
    o_rw       = 1'b1;
    o_pc_inc   = 1'b0;
    o_push_sel = PUSH_NONE;
    o_b_flag   = 1'b0;
    o_sp_dec   = 1'b0;
    o_0_adl0   = 1'b0;
    o_0_adl1   = 1'b0;
    o_0_adl2   = 1'b0;
    o_0_adh0   = 1'b0;
    o_0_adh1_7 = 1'b0;
    o_pcl_load = 1'b0;
    o_pch_load = 1'b0;
    o_set_i    = 1'b0;
    o_vec_kind = kind_q;
    o_done     = 1'b0;
    case (state_q)
      ST_T1: o_pc_inc = brk_q;
      ST_T3, ST_T4, ST_T5: begin
        // A suppressed RES still walks SP down on page 01, it just never writes.
        o_0_adh1_7 = 1'b1;
        o_sp_dec   = 1'b1;
        if (push_en) begin
          o_rw       = 1'b0;
          o_push_sel = (state_q == ST_T3) ? PUSH_PCH :
                       (state_q == ST_T4) ? PUSH_PCL : PUSH_P;
        end
        if (state_q == ST_T5)
          o_b_flag = brk_q;
      end
      ST_T6: begin
        o_pcl_load = 1'b1;
        o_set_i    = 1'b1;
        {o_0_adl2, o_0_adl1, o_0_adl0} = adl_mask(kind_q, 1'b0);
      end
      ST_T7: begin
        o_pch_load = 1'b1;
        o_done     = 1'b1;
        {o_0_adl2, o_0_adl1, o_0_adl0} = adl_mask(kind_q, 1'b1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_vector_sequencer.sv
// Directed bench for interrupt_vector_sequencer; expected per-cycle output words are hand-built.
// Inputs change 1ns after the rising edge, outputs are sampled there too.
// Words pack busy, rw, pc_inc, push_sel, b_flag, sp_dec, ADL, ADH, pcl, pch, set_i, kind, done.
module tb_interrupt_vector_sequencer;

  logic       clk;
  logic       i_reset, i_sync, i_res_req, i_nmi, i_irq, i_i_flag, i_brk;
  logic       o_busy, o_rw, o_pc_inc, o_b_flag, o_sp_dec;
  logic [1:0] o_push_sel, o_vec_kind;
  logic       o_0_adl0, o_0_adl1, o_0_adl2, o_0_adh0, o_0_adh1_7;
  logic       o_pcl_load, o_pch_load, o_set_i, o_done;

  int tests_run    = 0;
  int tests_failed = 0;

  interrupt_vector_sequencer dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_sync     (i_sync),
    .i_res_req  (i_res_req),
    .i_nmi      (i_nmi),
    .i_irq      (i_irq),
    .i_i_flag   (i_i_flag),
    .i_brk      (i_brk),
    .o_busy     (o_busy),
    .o_rw       (o_rw),
    .o_pc_inc   (o_pc_inc),
    .o_push_sel (o_push_sel),
    .o_b_flag   (o_b_flag),
    .o_sp_dec   (o_sp_dec),
    .o_0_adl0   (o_0_adl0),
    .o_0_adl1   (o_0_adl1),
    .o_0_adl2   (o_0_adl2),
    .o_0_adh0   (o_0_adh0),
    .o_0_adh1_7 (o_0_adh1_7),
    .o_pcl_load (o_pcl_load),
    .o_pch_load (o_pch_load),
    .o_set_i    (o_set_i),
    .o_vec_kind (o_vec_kind),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [28:0] pk(input int busy, rw, inc, push, b, spd, adl, adh,
                                     input int pcl, pch, si, kind, done);
    logic [7:0] al, ah;
    logic [1:0] ps, kd;
    al = adl[7:0];
    ah = adh[7:0];
    ps = push[1:0];
    kd = kind[1:0];
    return {busy[0], rw[0], inc[0], ps, b[0], spd[0], al, ah, pcl[0], pch[0], si[0], kd, done[0]};
  endfunction

  function automatic logic [28:0] obs();
    logic [7:0] adl, adh;
    adl = ~{5'b0, o_0_adl2, o_0_adl1, o_0_adl0};
    adh = ~{{7{o_0_adh1_7}}, o_0_adh0};
    return {o_busy, o_rw, o_pc_inc, o_push_sel, o_b_flag, o_sp_dec, adl, adh,
            o_pcl_load, o_pch_load, o_set_i, o_vec_kind, o_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [28:0] idle;
    idle = pk(0,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    i_reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (obs() !== idle) begin
      tests_failed++;
      $display("FAIL reset_idle got %h exp %h", obs(), idle);
    end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_irq();
    logic [28:0] ex [8];
    ex[0] = pk(1,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    ex[1] = pk(1,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    ex[2] = pk(1,0,0,1,0,1,'hFF,'h01,0,0,0,0,0);
    ex[3] = pk(1,0,0,2,0,1,'hFF,'h01,0,0,0,0,0);
    ex[4] = pk(1,0,0,3,0,1,'hFF,'h01,0,0,0,0,0);
    ex[5] = pk(1,1,0,0,0,0,'hFE,'hFF,1,0,1,0,0);
    ex[6] = pk(1,1,0,0,0,0,'hFF,'hFF,0,1,0,0,1);
    ex[7] = pk(0,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    i_irq = 1'b1; i_i_flag = 1'b0; i_sync = 1'b1;
    tick();
    i_sync = 1'b0; i_irq = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tests_run++;
      if (obs() !== ex[c]) begin
        tests_failed++;
        $display("FAIL irq_cycle%0d got %h exp %h", c, obs(), ex[c]);
      end
      tick();
    end
  endtask

  task automatic test_brk();
    logic [28:0] ex [8];
    ex[0] = pk(1,1,1,0,0,0,'hFF,'hFF,0,0,0,0,0);
    ex[1] = pk(1,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    ex[2] = pk(1,0,0,1,0,1,'hFF,'h01,0,0,0,0,0);
    ex[3] = pk(1,0,0,2,0,1,'hFF,'h01,0,0,0,0,0);
    ex[4] = pk(1,0,0,3,1,1,'hFF,'h01,0,0,0,0,0);
    ex[5] = pk(1,1,0,0,0,0,'hFE,'hFF,1,0,1,0,0);
    ex[6] = pk(1,1,0,0,0,0,'hFF,'hFF,0,1,0,0,1);
    ex[7] = pk(0,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    i_brk = 1'b1; i_sync = 1'b1;
    tick();
    i_sync = 1'b0; i_brk = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tests_run++;
      if (obs() !== ex[c]) begin
        tests_failed++;
        $display("FAIL brk_cycle%0d got %h exp %h", c, obs(), ex[c]);
      end
      tick();
    end
  endtask

  task automatic test_res();
    logic [28:0] ex [8];
    ex[0] = pk(1,1,0,0,0,0,'hFF,'hFF,0,0,0,2,0);
    ex[1] = pk(1,1,0,0,0,0,'hFF,'hFF,0,0,0,2,0);
    ex[2] = pk(1,1,0,0,0,1,'hFF,'h01,0,0,0,2,0);
    ex[3] = pk(1,1,0,0,0,1,'hFF,'h01,0,0,0,2,0);
    ex[4] = pk(1,1,0,0,0,1,'hFF,'h01,0,0,0,2,0);
    ex[5] = pk(1,1,0,0,0,0,'hFC,'hFF,1,0,1,2,0);
    ex[6] = pk(1,1,0,0,0,0,'hFD,'hFF,0,1,0,2,1);
    ex[7] = pk(0,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    i_res_req = 1'b1; i_irq = 1'b1; i_sync = 1'b1;
    tick();
    i_sync = 1'b0; i_res_req = 1'b0; i_irq = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tests_run++;
      if (obs() !== ex[c]) begin
        tests_failed++;
        $display("FAIL res_cycle%0d got %h exp %h", c, obs(), ex[c]);
      end
      tick();
    end
  endtask

  task automatic test_nmi_hijack();
    logic [28:0] ex [8];
    logic [28:0] idle;
    idle  = pk(0,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    ex[0] = pk(1,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    ex[1] = pk(1,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    ex[2] = pk(1,0,0,1,0,1,'hFF,'h01,0,0,0,0,0);
    ex[3] = pk(1,0,0,2,0,1,'hFF,'h01,0,0,0,0,0);
    ex[4] = pk(1,0,0,3,0,1,'hFF,'h01,0,0,0,1,0);
    ex[5] = pk(1,1,0,0,0,0,'hFA,'hFF,1,0,1,1,0);
    ex[6] = pk(1,1,0,0,0,0,'hFB,'hFF,0,1,0,1,1);
    ex[7] = pk(0,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    i_irq = 1'b1; i_i_flag = 1'b0; i_sync = 1'b1;
    tick();
    i_sync = 1'b0; i_irq = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tests_run++;
      if (obs() !== ex[c]) begin
        tests_failed++;
        $display("FAIL hijack_cycle%0d got %h exp %h", c, obs(), ex[c]);
      end
      if (c == 2) i_nmi = 1'b1;
      tick();
    end
    // The latch was consumed in T6, so a bare sync must not start anything.
    i_nmi = 1'b0; i_sync = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if (obs() !== idle) begin
        tests_failed++;
        $display("FAIL hijack_latch_clear%0d got %h exp %h", c, obs(), idle);
      end
    end
    i_sync = 1'b0;
  endtask

  task automatic test_masked_and_nmi_level();
    logic [28:0] idle;
    int          nseq;
    int          badkind;
    idle = pk(0,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    i_irq = 1'b1; i_i_flag = 1'b1; i_sync = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (obs() !== idle) begin
        tests_failed++;
        $display("FAIL masked_irq%0d got %h exp %h", c, obs(), idle);
      end
    end
    nseq = 0;
    badkind = 0;
    i_nmi = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 19) i_nmi = 1'b0;
      if (o_done) nseq++;
      if (o_busy && o_vec_kind !== 2'd1) badkind++;
    end
    tests_run++;
    if (nseq !== 1) begin
      tests_failed++;
      $display("FAIL nmi_level_seqs got %0d exp 1", nseq);
    end
    tests_run++;
    if (badkind !== 0) begin
      tests_failed++;
      $display("FAIL nmi_level_kind got %0d bad cycles exp 0", badkind);
    end
    i_irq = 1'b0; i_i_flag = 1'b0; i_sync = 1'b0;
    tick();
  endtask

  task automatic test_res_during_nmi();
    logic [28:0] e_t1n, e_t5n, e_t1r, e_t3r, e_t6r, e_t7r;
    e_t1n = pk(1,1,0,0,0,0,'hFF,'hFF,0,0,0,1,0);
    e_t5n = pk(1,0,0,3,0,1,'hFF,'h01,0,0,0,1,0);
    e_t1r = pk(1,1,0,0,0,0,'hFF,'hFF,0,0,0,2,0);
    e_t3r = pk(1,1,0,0,0,1,'hFF,'h01,0,0,0,2,0);
    e_t6r = pk(1,1,0,0,0,0,'hFC,'hFF,1,0,1,2,0);
    e_t7r = pk(1,1,0,0,0,0,'hFD,'hFF,0,1,0,2,1);
    i_nmi = 1'b1; i_sync = 1'b1;
    tick();
    tick();
    i_sync = 1'b0; i_nmi = 1'b0;
    tests_run++;
    if (obs() !== e_t1n) begin
      tests_failed++;
      $display("FAIL resnmi_t1 got %h exp %h", obs(), e_t1n);
    end
    repeat (4) tick();
    tests_run++;
    if (obs() !== e_t5n) begin
      tests_failed++;
      $display("FAIL resnmi_t5 got %h exp %h", obs(), e_t5n);
    end
    i_res_req = 1'b1;
    tick();
    i_res_req = 1'b0;
    tests_run++;
    if (obs() !== e_t1r) begin
      tests_failed++;
      $display("FAIL resnmi_restart got %h exp %h", obs(), e_t1r);
    end
    repeat (2) tick();
    tests_run++;
    if (obs() !== e_t3r) begin
      tests_failed++;
      $display("FAIL resnmi_t3 got %h exp %h", obs(), e_t3r);
    end
    repeat (3) tick();
    tests_run++;
    if (obs() !== e_t6r) begin
      tests_failed++;
      $display("FAIL resnmi_t6 got %h exp %h", obs(), e_t6r);
    end
    tick();
    tests_run++;
    if (obs() !== e_t7r) begin
      tests_failed++;
      $display("FAIL resnmi_t7 got %h exp %h", obs(), e_t7r);
    end
    tick();
  endtask

  task automatic test_reset_midseq();
    logic [28:0] e_t4, idle;
    e_t4 = pk(1,0,0,2,0,1,'hFF,'h01,0,0,0,1,0);
    idle = pk(0,1,0,0,0,0,'hFF,'hFF,0,0,0,0,0);
    // The NMI interrupted by RES above is still pending and starts here.
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (obs() !== e_t4) begin
      tests_failed++;
      $display("FAIL rstmid_t4 got %h exp %h", obs(), e_t4);
    end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tests_run++;
    if (obs() !== idle) begin
      tests_failed++;
      $display("FAIL rstmid_idle got %h exp %h", obs(), idle);
    end
    i_sync = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (obs() !== idle) begin
      tests_failed++;
      $display("FAIL rstmid_latch_clear got %h exp %h", obs(), idle);
    end
    i_sync = 1'b0;
    tick();
  endtask

  initial begin
    i_reset = 1'b1; i_sync = 1'b0; i_res_req = 1'b0; i_nmi = 1'b0;
    i_irq = 1'b0; i_i_flag = 1'b0; i_brk = 1'b0;
    test_reset();
    test_irq();
    test_brk();
    test_res();
    test_nmi_hijack();
    test_masked_and_nmi_level();
    test_res_during_nmi();
    test_reset_midseq();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
